// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the synchronous MIPS data memory.
// Provides access-size codes, FSM states, the byte-lane mask and the alignment predicate.
// Pure definitions only, so it has no latency and no flow control.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reserved size 2'b11 falls through to word handling.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load aligner: picks the addressed byte/half/word lanes out of a word and extends to 32 bits.
// Combinational, zero latency.
// No flow control; output follows the inputs.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] value
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: value = {{24{sel_byte[7] & ~unsigned_ld}}, sel_byte};
      SZ_HALF: value = {{16{sel_half[15] & ~unsigned_ld}}, sel_half};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/dmem_sync.sv
// Byte-addressed synchronous data memory with a post-reset clear sweep; DMEM_BYPASS_EN selects write-first reads.
// Writes land at the clock edge; reads register result with a one-cycle rd_valid strobe (latency 1).
// Never stalls in RUN; ready is low only while the clear sweep runs, and requests are ignored then.
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADDR_WIDTH-1:0] dir,
  input  logic [31:0]           dataInput,
  output logic [31:0]           result,
  output logic                  rd_valid,
  output logic                  ready,
  output logic                  misalign
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [IW-1:0] cnt;

  logic [IW-1:0] widx;
  logic [1:0]    off;
  logic          aligned;
  logic [3:0]    mask;
  logic [31:0]   wdata;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   rd_word;
  logic [31:0]   ld_value;
  logic          run;
  logic          unused_dir;

  // Upper address bits only alias onto the same words.
  assign unused_dir = ^dir;

  assign widx     = dir[IW+1:2];
  assign off      = dir[1:0];
  assign aligned  = is_aligned(size, off);
  assign mask     = lane_mask(size, off);
  assign old_word = mem[widx];
  assign run      = (state == ST_RUN);
  assign ready    = run;

  always_comb begin
    case (size)
      SZ_BYTE: wdata = {4{dataInput[7:0]}};
      SZ_HALF: wdata = {2{dataInput[15:0]}};
      default: wdata = dataInput;
    endcase
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
`ifdef DMEM_BYPASS_EN
    rd_word = MemWrite ? merged : old_word;
`else
    rd_word = old_word;
`endif
  end

  dmem_load_align u_load_align (
    .word        (rd_word),
    .offset      (off),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .value       (ld_value)
  );

  // Storage carries no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else if (MemWrite && aligned) begin
        mem[widx] <= merged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt      <= '0;
      result   <= '0;
      rd_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      misalign <= 1'b0;
      if (!run) begin
        cnt <= cnt + 1'b1;
        if (cnt == IW'(DEPTH - 1)) state <= ST_RUN;
      end else if (MemRead || MemWrite) begin
        if (!aligned) begin
          misalign <= 1'b1;
        end else if (MemRead) begin
          result   <= ld_value;
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_sync.sv
// Randomized and directed self-checking bench for dmem_sync against a byte-array reference model.
module tb_dmem_sync;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        unsigned_ld = 1'b0;
  logic [31:0] dir = '0;
  logic [31:0] dataInput = '0;
  logic [31:0] result;
  logic        rd_valid;
  logic        ready;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mref [128];
  logic [31:0] exp_result = '0;
  logic        exp_vld = 1'b0;
  logic        exp_mis = 1'b0;

  dmem_sync #(.DEPTH(32), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .dir         (dir),
    .dataInput   (dataInput),
    .result      (result),
    .rd_valid    (rd_valid),
    .ready       (ready),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int n = nbytes(sz);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      logic [6:0] idx = a[6:0] + 7'(i);
      v = v | (32'(mref[idx]) << (8 * i));
    end
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) begin
      logic [6:0] idx = a[6:0] + 7'(i);
      mref[idx] = d[8*i +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) mref[i] = 8'h00;
    exp_result = '0;
    exp_vld = 1'b0;
    exp_mis = 1'b0;
  endtask

  // Drives one request for one clock and updates the expected outputs.
  task automatic step(input logic mw, input logic mr, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    logic al;
    logic [31:0] pre;
    @(negedge clk);
    MemWrite = mw; MemRead = mr; size = sz; unsigned_ld = u; dir = a; dataInput = d;
    al = (sz == 2'b00) ? 1'b1 : (sz == 2'b01) ? ~a[0] : (a[1:0] == 2'b00);
    exp_vld = 1'b0;
    exp_mis = 1'b0;
    if (mw || mr) begin
      if (!al) begin
        exp_mis = 1'b1;
      end else begin
        pre = mload(a, sz, u);
        if (mw) mstore(a, sz, d);
        if (mr) begin
`ifdef DMEM_BYPASS_EN
          exp_result = mload(a, sz, u);
`else
          exp_result = pre;
`endif
          exp_vld = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    #2 reset = 1'b1;
    #1;
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL sweep_len: got %0d cycles want 32", n); end
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL lw_word5: got %h want 00000000", result); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL lw_word5_vld: got %b want 1", rd_valid); end
    step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL vld_pulse: got %b want 0", rd_valid); end
  endtask

  task automatic test_subword();
    logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10};
    logic [1:0]  szs   [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        uns   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] want  [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD, 32'hDEAD5AEF};
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) step(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0000005A);
      step(1'b0, 1'b1, szs[i], uns[i], addrs[i], 32'h0);
      checks++;
      if (result !== want[i] || result !== exp_result) begin
        errors++;
        $display("FAIL subword_%0d: got %h want %h", i, result, want[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] held = exp_result;
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h06, 32'h0);
    checks++; if (misalign !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL mis_lw: mis=%b vld=%b want 1/0", misalign, rd_valid); end
    checks++; if (result !== held) begin errors++; $display("FAIL mis_lw_hold: got %h want %h", result, held); end
    step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misalign); end
    step(1'b1, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0000FFFF);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_sh: got %b want 1", misalign); end
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF);
    checks++; if (misalign !== 1'b1 || rd_valid !== 1'b0 || result !== held) begin
      errors++; $display("FAIL mis_both: mis=%b vld=%b res=%h want 1/0/%h", misalign, rd_valid, result, held);
    end
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0);
    checks++; if (result !== 32'h0 || misalign !== 1'b0) begin errors++; $display("FAIL mis_nowrite0: got %h want 00000000", result); end
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (result !== 32'hDEAD5AEF) begin errors++; $display("FAIL mis_nowrite10: got %h want deadbeef-merged", result); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] want;
`ifdef DMEM_BYPASS_EN
    want = 32'h12345678;
`else
    want = 32'h00000000;
`endif
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    checks++; if (result !== want || result !== exp_result || rd_valid !== 1'b1) begin
      errors++; $display("FAIL rw_same: got %h vld=%b want %h", result, rd_valid, want);
    end
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++; if (result !== 32'h12345678) begin errors++; $display("FAIL rw_after: got %h want 12345678", result); end
  endtask

  task automatic test_reset_midsweep();
    int n;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midsweep_ready: got %b want 0", ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (result !== 32'h0 || ready !== 1'b0) begin errors++; $display("FAIL midsweep_reset: res=%h rdy=%b want 0/0", result, ready); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL midsweep_len: got %0d cycles want 32", n); end
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL cleared_20: got %h want 00000000", result); end
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'hA5A50F0F);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0);
    checks++; if (result !== 32'hA5A50F0F) begin errors++; $display("FAIL wrap_80: got %h want a5a50f0f", result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b00) a[1:0] = 2'b00;
      end
      step(1'($urandom), 1'($urandom), sz, 1'($urandom), a, $urandom);
      checks++; if (result !== exp_result) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", i, result, exp_result); end
      checks++; if (rd_valid !== exp_vld) begin errors++; $display("FAIL rand_vld[%0d]: got %b want %b", i, rd_valid, exp_vld); end
      checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rand_mis[%0d]: got %b want %b", i, misalign, exp_mis); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_subword();
    test_misalign();
    test_simultaneous();
    test_back_to_back();
    test_reset_midsweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
